output_ctrl_merge: RTL

// - Output-side merge stage of a tree NoC router port; the counterpart of the input

---
 rtl/output_ctrl_merge.sv | 123 ++++++++++++
 1 files changed

// File: rtl/output_ctrl_merge.sv
// Two-source round-robin merge onto one downstream 4-phase req/ack link.
// Optional DROP_ILLEGAL_EN discards packets whose dest field equals their addr field.
module output_ctrl_merge #(
   parameter int WIDTH_packet = 14,
   parameter int WIDTH_addr   = 3,
   parameter int WIDTH_dest   = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in1_req,
   output logic                    in1_ack,
   input  logic [WIDTH_packet-1:0] in1_data,
   input  logic                    in2_req,
   output logic                    in2_ack,
   input  logic [WIDTH_packet-1:0] in2_data,
   output logic                    out_req,
   input  logic                    out_ack,
   output logic [WIDTH_packet-1:0] out_data,
   output logic                    drop_pulse
);

   typedef enum logic [1:0] {IDLE, L_REL, O_ACK, O_REL} state_t;

   state_t                  state_q, state_d;
   logic                    win2_q, win2_d;     // current winner is source 2
   logic                    last2_q, last2_d;   // last grant went to source 2
   logic                    in1_ack_q, in1_ack_d;
   logic                    in2_ack_q, in2_ack_d;
   logic                    out_req_q, out_req_d;
   logic                    drop_q, drop_d;
   logic [WIDTH_packet-1:0] out_data_q, out_data_d;
   logic                    grant2;
   logic                    win_req;
`ifdef DROP_ILLEGAL_EN
   logic                    illegal;

   assign illegal = out_data_q[WIDTH_packet-1 -: WIDTH_addr] ==
                    out_data_q[WIDTH_packet-WIDTH_addr-1 -: WIDTH_dest];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         win2_q     <= 1'b0;
         last2_q    <= 1'b1;
         in1_ack_q  <= 1'b0;
         in2_ack_q  <= 1'b0;
         out_req_q  <= 1'b0;
         drop_q     <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         win2_q     <= win2_d;
         last2_q    <= last2_d;
         in1_ack_q  <= in1_ack_d;
         in2_ack_q  <= in2_ack_d;
         out_req_q  <= out_req_d;
         drop_q     <= drop_d;
         out_data_q <= out_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      win2_d     = win2_q;
      last2_d    = last2_q;
      in1_ack_d  = in1_ack_q;
      in2_ack_d  = in2_ack_q;
      out_req_d  = out_req_q;
      out_data_d = out_data_q;
      drop_d     = 1'b0;
      // Source 2 wins when alone, or when both ask and source 1 was served last.
      grant2     = in2_req & (~in1_req | ~last2_q);
      win_req    = win2_q ? in2_req : in1_req;
      case (state_q)
         IDLE: begin
            if (in1_req || in2_req) begin
               win2_d     = grant2;
               last2_d    = grant2;
               out_data_d = grant2 ? in2_data : in1_data;
               in1_ack_d  = ~grant2;
               in2_ack_d  = grant2;
               state_d    = L_REL;
            end
         end
         L_REL: begin
            if (!win_req) begin
               in1_ack_d = 1'b0;
               in2_ack_d = 1'b0;
`ifdef DROP_ILLEGAL_EN
               if (illegal) begin
                  drop_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  out_req_d = 1'b1;
                  state_d   = O_ACK;
               end
`else
               out_req_d = 1'b1;
               state_d   = O_ACK;
`endif
            end
         end
         O_ACK: begin
            if (out_ack) begin
               out_req_d = 1'b0;
               state_d   = O_REL;
            end
         end
         O_REL: begin
            if (!out_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in1_ack    = in1_ack_q;
   assign in2_ack    = in2_ack_q;
   assign out_req    = out_req_q;
   assign out_data   = out_data_q;
   assign drop_pulse = drop_q;

endmodule
